run_controller: RTL

RUN_CONTROLLER -- requirements
Module: run_controller

---
 rtl/run_ctrl_pkg.sv | 14 +
 rtl/run_controller_sat_counter.sv | 24 ++
 rtl/run_controller.sv | 122 ++++++++++++
 3 files changed

// File: rtl/run_ctrl_pkg.sv
// Shared definitions for the run controller: FSM state encoding and the
// halt/tohost value that marks a passing run.
package run_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    RUN    = 2'd2,
    FINISH = 2'd3
  } run_state_e;

  localparam logic [31:0] HALT_PASS_CODE = 32'h1;

endpackage

// File: rtl/run_controller_sat_counter.sv
// Saturating up-counter: synchronous clear has priority, then increment,
// and the count sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
    return (v == '1) ? v : v + W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (inc) begin
      q <= sat_inc(q);
    end
  end

endmodule

// File: rtl/run_controller.sv
// Run controller: holds a CPU core in reset, releases it for a bounded run and
// reports halt/pass/timeout. Define RUN_CTRL_TOHOST_CHECK_EN to require halt_code==1 for pass.
module run_controller
  import run_ctrl_pkg::*;
#(
  parameter int RESET_CYCLES = 4,
  parameter int MAX_CYCLES   = 30,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             halt_valid,
  input  logic [31:0]      halt_code,
  output logic             core_reset,
  output logic             running,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_count
);

  // One phase counter times both HOLD and the RUN budget; it must cover
  // MAX_CYCLES even when cycle_count is narrow and saturates early.
  localparam int BUD_W = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES + 1) : 1;
  localparam int PH_W  = (BUD_W > 8) ? BUD_W : 8;
  localparam logic [PH_W-1:0] HOLD_LAST = PH_W'(RESET_CYCLES - 1);
  localparam logic [PH_W-1:0] RUN_LAST  = PH_W'(MAX_CYCLES - 1);

  run_state_e      state, state_nxt;
  logic            done_nxt, pass_nxt, timeout_nxt;
  logic            cnt_clr;
  logic            halt_ok;
  logic [PH_W-1:0] phase_q;
  logic            phase_clr, phase_inc;
  logic            cyc_clr, cyc_inc;

`ifdef RUN_CTRL_TOHOST_CHECK_EN
  assign halt_ok = (halt_code == HALT_PASS_CODE);
`else
  logic unused_halt_code;
  assign unused_halt_code = ^(halt_code ^ HALT_PASS_CODE);
  assign halt_ok          = 1'b1;
`endif

  always_comb begin
    state_nxt   = state;
    done_nxt    = done;
    pass_nxt    = pass;
    timeout_nxt = timeout;
    cnt_clr     = 1'b0;
    case (state)
      IDLE, FINISH: begin
        if (start) begin
          state_nxt   = HOLD;
          done_nxt    = 1'b0;
          pass_nxt    = 1'b0;
          timeout_nxt = 1'b0;
          cnt_clr     = 1'b1;
        end
      end
      HOLD: begin
        if (phase_q == HOLD_LAST) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        // A halt on the last budget cycle still counts as a halt.
        if (halt_valid) begin
          state_nxt = FINISH;
          done_nxt  = 1'b1;
          pass_nxt  = halt_ok;
        end else if (phase_q == RUN_LAST) begin
          state_nxt   = FINISH;
          done_nxt    = 1'b1;
          timeout_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      done    <= 1'b0;
      pass    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state   <= state_nxt;
      done    <= done_nxt;
      pass    <= pass_nxt;
      timeout <= timeout_nxt;
    end
  end

  // Phase restarts from zero on every state change, so in RUN it holds
  // (run cycle - 1) and in HOLD it holds (hold cycle - 1).
  assign phase_clr = !reset || (state_nxt != state);
  assign phase_inc = (state == HOLD) || (state == RUN);

  sat_counter #(.W(PH_W)) u_phase (
    .clk (clk),
    .clr (phase_clr),
    .inc (phase_inc),
    .q   (phase_q)
  );

  assign cyc_clr = !reset || cnt_clr;
  assign cyc_inc = (state == RUN);

  sat_counter #(.W(CNT_W)) u_cycles (
    .clk (clk),
    .clr (cyc_clr),
    .inc (cyc_inc),
    .q   (cycle_count)
  );

  assign core_reset = (state != RUN);
  assign running    = (state == RUN);

endmodule
